seg_scan_driver: RTL

Parametrised, time-multiplexed driver for a common-anode, active-low multi-digit 7-segment display. It holds one hex nibble, one decimal point and one blank flag per digit, scans the digits round-robin at a programmable refresh rate, and decodes each nibble to segments. A load pulse buffers new values into shadow registers, which are applied only at frame boundaries, so the display never shows a torn value.

---
 rtl/seg_scan_driver.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with frame-synchronous shadow loading.
// Define LEADING_ZERO_BLANK_EN to suppress leading zero digits (digit 0 is never suppressed).
module seg_scan_driver #(
   parameter int DIGITS      = 4,
   parameter int REFRESH_DIV = 100000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [4*DIGITS-1:0] value,
   input  logic [DIGITS-1:0]   dp_in,
   input  logic [DIGITS-1:0]   blank,
   input  logic                load,
   output logic [6:0]          seg,
   output logic                dp,
   output logic [DIGITS-1:0]   an,
   output logic                frame_done
);

   localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] IDX_MAX   = IW'(DIGITS - 1);

   logic [PW-1:0]       r_presc;
   logic [IW-1:0]       r_idx;
   logic [4*DIGITS-1:0] r_sh_val, r_disp_val;
   logic [DIGITS-1:0]   r_sh_dp, r_sh_blank, r_disp_dp, r_disp_blank;
   logic                r_pending;
   logic [6:0]          r_seg;
   logic                r_dp;
   logic [DIGITS-1:0]   r_an;
   logic                r_frame_done;

   logic                w_tick, w_boundary;
   logic [3:0]          w_nib;
   logic                w_dp_bit, w_off;
   logic [DIGITS-1:0]   w_an, w_lz;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   assign w_tick     = (r_presc == PRESC_MAX);
   assign w_boundary = w_tick && (r_idx == IDX_MAX);

`ifdef LEADING_ZERO_BLANK_EN
   // Walk down from the top digit; a digit is suppressed while everything at or above it is zero.
   always_comb begin
      logic v_hi_zero;
      v_hi_zero = 1'b1;
      w_lz      = '0;
      for (int i = DIGITS - 1; i > 0; i--) begin
         v_hi_zero = v_hi_zero && (r_disp_val[4*i +: 4] == 4'h0);
         w_lz[i]   = v_hi_zero && !r_disp_dp[i];
      end
   end
`else
   assign w_lz = '0;
`endif

   // Digit select as a compare-per-digit mux so no out-of-range index can ever be formed.
   // NOTE: every output of this block gets a default first, otherwise a latch is inferred.
   always_comb begin
      w_nib    = 4'h0;
      w_dp_bit = 1'b0;
      w_off    = 1'b0;
      w_an     = '1;
      for (int i = 0; i < DIGITS; i++) begin
         if (r_idx == IW'(i)) begin
            w_nib    = r_disp_val[4*i +: 4];
            w_dp_bit = r_disp_dp[i];
            w_off    = r_disp_blank[i] || w_lz[i];
            w_an[i]  = 1'b0;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_presc <= '0;
         r_idx   <= '0;
      end else if (w_tick) begin
         r_presc <= '0;
         r_idx   <= (r_idx == IDX_MAX) ? '0 : r_idx + IW'(1);
      end else begin
         r_presc <= r_presc + PW'(1);
      end
   end

   // NOTE: shadow and display registers are reset explicitly; the first frame must show zeros.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sh_val     <= '0;
         r_sh_dp      <= '0;
         r_sh_blank   <= '0;
         r_disp_val   <= '0;
         r_disp_dp    <= '0;
         r_disp_blank <= '0;
         r_pending    <= 1'b0;
      end else if (w_boundary) begin
         r_pending <= 1'b0;
         if (load) begin
            r_disp_val   <= value;
            r_disp_dp    <= dp_in;
            r_disp_blank <= blank;
         end else if (r_pending) begin
            r_disp_val   <= r_sh_val;
            r_disp_dp    <= r_sh_dp;
            r_disp_blank <= r_sh_blank;
         end
      end else if (load) begin
         r_sh_val   <= value;
         r_sh_dp    <= dp_in;
         r_sh_blank <= blank;
         r_pending  <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_an         <= '1;
         r_seg        <= 7'h7F;
         r_dp         <= 1'b1;
         r_frame_done <= 1'b0;
      end else begin
         r_an         <= w_an;
         r_seg        <= w_off ? 7'h7F : hex_to_seg(w_nib);
         r_dp         <= w_off ? 1'b1 : ~w_dp_bit;
         r_frame_done <= w_boundary;
      end
   end

   assign an         = r_an;
   assign seg        = r_seg;
   assign dp         = r_dp;
   assign frame_done = r_frame_done;

endmodule
